// File: rtl/wired_commit_nw.sv
// wired_commit_nw: N-wide in-order commit stage.
// Selects a legal retire group at the ROB head, registers it into a
// handle stage (H) and resolves exceptions/uncached ops with a small FSM.
// Ports:
//   clk, rst          clock, sync active-high reset
//   rob_*_i           ROB head slots (valid/wreg/wdata/excp/single/uncached/store)
//   rob_head_o        ROB index of slot 0
//   retire_o          ROB pop mask (thermometer)
//   lsu_req_*_o       uncached request, lsu_resp_*_i its completion
//   l_*_o             registered rename retire / ARF write bundle, flush
//   rename_empty_i    pipeline drained, ends the flush
//   excp_*_o          one-cycle exception report
//   retired_cnt_o     committed instruction counter
module wired_commit_nw #(
  parameter int COMMIT_W = 2,
  parameter int ROB_LEN  = 5,
  parameter int ARF_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COMMIT_W-1:0]          rob_valid_i,
  input  logic [COMMIT_W*ARF_W-1:0]    rob_wreg_i,
  input  logic [COMMIT_W*DATA_W-1:0]   rob_wdata_i,
  input  logic [COMMIT_W-1:0]          rob_excp_i,
  input  logic [COMMIT_W-1:0]          rob_single_i,
  input  logic [COMMIT_W-1:0]          rob_uncached_i,
  input  logic [COMMIT_W-1:0]          rob_store_i,
  output logic [ROB_LEN-1:0]           rob_head_o,
  output logic [COMMIT_W-1:0]          retire_o,
  output logic                         lsu_req_valid_o,
  output logic                         lsu_req_store_o,
  output logic [ROB_LEN-1:0]           lsu_req_rrid_o,
  input  logic                         lsu_resp_ready_i,
  input  logic [DATA_W-1:0]            lsu_resp_data_i,
  output logic [COMMIT_W-1:0]          l_retire_o,
  output logic [COMMIT_W-1:0]          l_commit_o,
  output logic [COMMIT_W*ARF_W-1:0]    l_warid_o,
  output logic [COMMIT_W*ROB_LEN-1:0]  l_wrrid_o,
  output logic [COMMIT_W*DATA_W-1:0]   l_data_o,
  output logic                         l_flush_o,
  input  logic                         rename_empty_i,
  output logic                         excp_valid_o,
  output logic [ROB_LEN-1:0]           excp_rrid_o,
  output logic [31:0]                  retired_cnt_o
);

  typedef enum logic [1:0] {
    NORMAL,
    WAIT_ULOAD,
    WAIT_USTORE,
    WAIT_FLUSH
  } state_t;

  state_t state_q, state_n;

  logic [ROB_LEN-1:0]          head_q;
  logic [COMMIT_W-1:0]         sel;
  logic                        blk0;
  logic                        run;
  logic                        h_ready;

  logic [COMMIT_W-1:0]         h_valid;
  logic [COMMIT_W-1:0]         h_excp;
  logic [COMMIT_W-1:0]         h_unc;
  logic [COMMIT_W-1:0]         h_store;
  logic [COMMIT_W*ARF_W-1:0]   h_wreg;
  logic [COMMIT_W*DATA_W-1:0]  h_data;
  logic [COMMIT_W*ROB_LEN-1:0] h_rrid;
  logic [COMMIT_W*ROB_LEN-1:0] rrid_n;

  logic [COMMIT_W-1:0]         ret_n;
  logic [COMMIT_W-1:0]         com_n;
  logic [COMMIT_W*DATA_W-1:0]  data_n;
  logic                        excp_n;
  logic [31:0]                 cnt_q;

  // Only slot 0 of these flags steers the FSM; younger slots never
  // hold excp/uncached because selection stops in front of them.
  logic unused_h;
  assign unused_h = ^{h_excp, h_unc, h_store};

  function automatic int unsigned popcnt(input logic [COMMIT_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < COMMIT_W; i++) c += 32'(v[i]);
    return c;
  endfunction

  // A special head instruction (single/excp/uncached) retires alone.
  assign blk0 = rob_single_i[0] | rob_excp_i[0] | rob_uncached_i[0];

  always_comb begin
    sel = '0;
    run = rob_valid_i[0];
    sel[0] = run;
    for (int k = 1; k < COMMIT_W; k++) begin
      run = run & rob_valid_i[k] & ~blk0 & ~rob_single_i[k]
          & ~rob_excp_i[k] & ~rob_uncached_i[k];
      for (int j = 0; j < k; j++) begin
        if (rob_wreg_i[k*ARF_W +: ARF_W] != '0 &&
            rob_wreg_i[k*ARF_W +: ARF_W] == rob_wreg_i[j*ARF_W +: ARF_W])
          run = 1'b0;
      end
      sel[k] = run;
    end
  end

  always_comb begin
    rrid_n = '0;
    for (int k = 0; k < COMMIT_W; k++)
      rrid_n[k*ROB_LEN +: ROB_LEN] = head_q + ROB_LEN'(k);
  end

  assign retire_o   = h_ready ? sel : '0;
  assign rob_head_o = head_q;

  always_ff @(posedge clk) begin
    if (rst) head_q <= '0;
    else     head_q <= head_q + ROB_LEN'(popcnt(retire_o));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid <= '0;
      h_excp  <= '0;
      h_unc   <= '0;
      h_store <= '0;
      h_wreg  <= '0;
      h_data  <= '0;
      h_rrid  <= '0;
    end else if (h_ready) begin
      h_valid <= sel;
      h_excp  <= rob_excp_i;
      h_unc   <= rob_uncached_i;
      h_store <= rob_store_i;
      h_wreg  <= rob_wreg_i;
      h_data  <= rob_wdata_i;
      h_rrid  <= rrid_n;
    end
  end

  always_comb begin
    state_n = state_q;
    h_ready = 1'b0;
    ret_n   = '0;
    com_n   = '0;
    excp_n  = 1'b0;
    data_n  = h_data;
    unique case (state_q)
      NORMAL: begin
        if (h_valid[0] & h_excp[0]) begin
          ret_n[0] = 1'b1;
          excp_n   = 1'b1;
          h_ready  = 1'b1;
          state_n  = WAIT_FLUSH;
        end else if (h_valid[0] & h_unc[0]) begin
          state_n = h_store[0] ? WAIT_USTORE : WAIT_ULOAD;
        end else begin
          ret_n   = h_valid;
          com_n   = h_valid;
          h_ready = 1'b1;
        end
      end
      WAIT_ULOAD: begin
        if (lsu_resp_ready_i) begin
          ret_n[0]            = 1'b1;
          com_n[0]            = 1'b1;
          data_n[DATA_W-1:0]  = lsu_resp_data_i;
          h_ready             = 1'b1;
          state_n             = WAIT_FLUSH;
        end
      end
      WAIT_USTORE: begin
        if (lsu_resp_ready_i) begin
          ret_n[0] = 1'b1;
          com_n[0] = 1'b1;
          h_ready  = 1'b1;
          state_n  = NORMAL;
        end
      end
      WAIT_FLUSH: begin
        // Younger entries are popped and drained without writing the ARF.
        h_ready = 1'b1;
        ret_n   = h_valid;
        if (rename_empty_i) state_n = NORMAL;
      end
      default: state_n = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      l_retire_o   <= '0;
      l_commit_o   <= '0;
      l_warid_o    <= '0;
      l_wrrid_o    <= '0;
      l_data_o     <= '0;
      excp_valid_o <= 1'b0;
      excp_rrid_o  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_n;
      l_retire_o   <= ret_n;
      l_commit_o   <= com_n;
      l_warid_o    <= h_wreg;
      l_wrrid_o    <= h_rrid;
      l_data_o     <= data_n;
      excp_valid_o <= excp_n;
      excp_rrid_o  <= excp_n ? h_rrid[ROB_LEN-1:0] : '0;
      cnt_q        <= cnt_q + popcnt(com_n) + 32'(excp_n);
    end
  end

  // Flush and LSU request follow the state register directly.
  assign l_flush_o       = (state_q == WAIT_FLUSH);
  assign lsu_req_valid_o = (state_q == WAIT_ULOAD) || (state_q == WAIT_USTORE);
  assign lsu_req_store_o = (state_q == WAIT_USTORE);
  assign lsu_req_rrid_o  = lsu_req_valid_o ? h_rrid[ROB_LEN-1:0] : '0;
  assign retired_cnt_o   = cnt_q;

endmodule

// File: tb/tb_wired_commit_nw.sv
// tb_wired_commit_nw: directed bench for the 4-wide commit stage.
// ROB/commit-stream model in the bench plus literal expectations.
module tb_wired_commit_nw;
  localparam int W  = 4;
  localparam int RL = 5;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    rob_valid_i, rob_excp_i, rob_single_i;
  logic [W-1:0]    rob_uncached_i, rob_store_i;
  logic [W*AW-1:0] rob_wreg_i;
  logic [W*DW-1:0] rob_wdata_i;
  logic [RL-1:0]   rob_head_o;
  logic [W-1:0]    retire_o;
  logic            lsu_req_valid_o, lsu_req_store_o;
  logic [RL-1:0]   lsu_req_rrid_o;
  logic            lsu_resp_ready_i;
  logic [DW-1:0]   lsu_resp_data_i;
  logic [W-1:0]    l_retire_o, l_commit_o;
  logic [W*AW-1:0] l_warid_o;
  logic [W*RL-1:0] l_wrrid_o;
  logic [W*DW-1:0] l_data_o;
  logic            l_flush_o;
  logic            rename_empty_i;
  logic            excp_valid_o;
  logic [RL-1:0]   excp_rrid_o;
  logic [31:0]     retired_cnt_o;

  always #5 clk = ~clk;

  wired_commit_nw #(.COMMIT_W(W), .ROB_LEN(RL), .ARF_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .rob_valid_i(rob_valid_i), .rob_wreg_i(rob_wreg_i),
    .rob_wdata_i(rob_wdata_i), .rob_excp_i(rob_excp_i),
    .rob_single_i(rob_single_i), .rob_uncached_i(rob_uncached_i),
    .rob_store_i(rob_store_i), .rob_head_o(rob_head_o),
    .retire_o(retire_o), .lsu_req_valid_o(lsu_req_valid_o),
    .lsu_req_store_o(lsu_req_store_o), .lsu_req_rrid_o(lsu_req_rrid_o),
    .lsu_resp_ready_i(lsu_resp_ready_i), .lsu_resp_data_i(lsu_resp_data_i),
    .l_retire_o(l_retire_o), .l_commit_o(l_commit_o),
    .l_warid_o(l_warid_o), .l_wrrid_o(l_wrrid_o), .l_data_o(l_data_o),
    .l_flush_o(l_flush_o), .rename_empty_i(rename_empty_i),
    .excp_valid_o(excp_valid_o), .excp_rrid_o(excp_rrid_o),
    .retired_cnt_o(retired_cnt_o)
  );

  typedef struct {
    logic [AW-1:0] wreg;
    logic [DW-1:0] data;
    logic [DW-1:0] ldata;
    logic excp, single, unc, store;
  } ent_t;

  typedef struct {
    logic [RL-1:0] rrid;
    logic [AW-1:0] wreg;
    logic [DW-1:0] data;
    logic commit;
    logic excp;
  } ev_t;

  ent_t          rob_q[$];
  ev_t           ev_q[$];
  logic [RL-1:0] exc_q[$];

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [RL-1:0] head_m;
  logic [31:0]   cnt_m;
  logic          unc_wait, draining;
  logic          lsu_rdy_v, ren_v;
  logic [DW-1:0] lsu_data_v;
  logic [W-1:0]  last_ret;
  bit            chk_en;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] wreg, input logic [DW-1:0] data,
                      input logic excp, input logic unc, input logic store,
                      input logic [DW-1:0] ldata);
    ent_t e;
    e.wreg = wreg; e.data = data; e.ldata = ldata;
    e.excp = excp; e.single = 1'b0; e.unc = unc; e.store = store;
    rob_q.push_back(e);
  endtask

  // Legal retire group from the ROB contents, per the selection rules.
  function automatic logic [W-1:0] sel_model();
    logic [W-1:0] s;
    logic stop;
    int n;
    s = '0;
    stop = 1'b0;
    n = (rob_q.size() > W) ? W : rob_q.size();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        if (rob_q[k].excp || rob_q[k].single || rob_q[k].unc) stop = 1'b1;
        if (rob_q[0].excp || rob_q[0].single || rob_q[0].unc) stop = 1'b1;
        for (int j = 0; j < k; j++)
          if (rob_q[k].wreg != 0 && rob_q[k].wreg == rob_q[j].wreg) stop = 1'b1;
      end
      if (!stop) s[k] = 1'b1;
    end
    return s;
  endfunction

  task automatic drive();
    rob_valid_i = '0; rob_wreg_i = '0; rob_wdata_i = '0;
    rob_excp_i = '0; rob_single_i = '0; rob_uncached_i = '0; rob_store_i = '0;
    for (int k = 0; k < W; k++) begin
      if (k < rob_q.size()) begin
        rob_valid_i[k] = 1'b1;
        rob_wreg_i[k*AW +: AW]  = rob_q[k].wreg;
        rob_wdata_i[k*DW +: DW] = rob_q[k].data;
        rob_excp_i[k]     = rob_q[k].excp;
        rob_single_i[k]   = rob_q[k].single;
        rob_uncached_i[k] = rob_q[k].unc;
        rob_store_i[k]    = rob_q[k].store;
      end
    end
    lsu_resp_ready_i = lsu_rdy_v;
    lsu_resp_data_i  = lsu_data_v;
    rename_empty_i   = ren_v;
  endtask

  task automatic cycle();
    logic [W-1:0] er;
    ent_t e;
    ev_t v;
    @(negedge clk);
    drive();
    #1;
    er = (unc_wait && !lsu_rdy_v) ? '0 : sel_model();
    last_ret = retire_o;
    chk("retire", 160'(retire_o), 160'(er));
    chk("head", 160'(rob_head_o), 160'(head_m));
    @(posedge clk);
    #1;
    if (ren_v) draining = 1'b0;
    if (unc_wait && lsu_rdy_v) unc_wait = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (er[k]) begin
        e = rob_q.pop_front();
        v.rrid = head_m; v.wreg = e.wreg; v.excp = e.excp;
        v.commit = !draining && !e.excp;
        v.data = (e.unc && !e.store) ? e.ldata : e.data;
        ev_q.push_back(v);
        if (e.excp) begin
          exc_q.push_back(head_m);
          draining = 1'b1;
        end
        if (e.unc) begin
          unc_wait = 1'b1;
          if (!e.store) draining = 1'b1;
        end
        head_m = head_m + 1'b1;
      end
    end
  endtask

  // Commit stream must match the in-order retire events one by one.
  always @(negedge clk) begin
    if (chk_en) begin
      ev_t v;
      for (int k = 0; k < W; k++) begin
        if (l_retire_o[k]) begin
          if (ev_q.size() == 0) begin
            chk("extra_retire", 160'(l_retire_o), 160'(0));
          end else begin
            v = ev_q.pop_front();
            chk("warid", 160'(l_warid_o[k*AW +: AW]), 160'(v.wreg));
            chk("wrrid", 160'(l_wrrid_o[k*RL +: RL]), 160'(v.rrid));
            chk("commit", 160'(l_commit_o[k]), 160'(v.commit));
            if (v.commit)
              chk("data", 160'(l_data_o[k*DW +: DW]), 160'(v.data));
            if (v.commit || v.excp) cnt_m = cnt_m + 1;
          end
        end else begin
          chk("stray_commit", 160'(l_commit_o[k]), 160'(0));
        end
      end
      if (excp_valid_o) begin
        if (exc_q.size() == 0) chk("extra_excp", 160'(excp_rrid_o), 160'(0));
        else chk("excp_rrid", 160'(excp_rrid_o), 160'(exc_q.pop_front()));
      end
      chk("cnt", 160'(retired_cnt_o), 160'(cnt_m));
    end
  end

  task automatic wait_req();
    int n;
    n = 0;
    while (!lsu_req_valid_o && n < 10) begin
      cycle();
      n++;
    end
    chk("req_seen", 160'(lsu_req_valid_o), 160'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    chk_en = 0; rst = 1'b1;
    head_m = '0; cnt_m = '0; unc_wait = 0; draining = 0;
    lsu_rdy_v = 0; ren_v = 0; lsu_data_v = '0; last_ret = '0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_head", 160'(rob_head_o), 160'(0));
    chk("rst_cnt", 160'(retired_cnt_o), 160'(0));
    chk("rst_outs", 160'({l_retire_o, l_commit_o, l_flush_o,
        lsu_req_valid_o, excp_valid_o}), 160'(0));
    chk_en = 1;

    // Full-width group
    for (int k = 1; k <= 4; k++) push(AW'(k), 32'h100 + k, 0, 0, 0, 0);
    cycle();
    chk("t1_ret", 160'(last_ret), 160'(4'b1111));
    chk("t1_head", 160'(rob_head_o), 160'(4));
    cycle();
    chk("t1_commit", 160'(l_commit_o), 160'(4'b1111));
    chk("t1_cnt", 160'(retired_cnt_o), 160'(4));

    // Same-register conflict splits the group
    push(1, 32'h201, 0, 0, 0, 0);
    push(2, 32'h202, 0, 0, 0, 0);
    push(1, 32'h203, 0, 0, 0, 0);
    push(3, 32'h204, 0, 0, 0, 0);
    cycle();
    chk("t2_ret_a", 160'(last_ret), 160'(4'b0011));
    cycle();
    chk("t2_ret_b", 160'(last_ret), 160'(4'b0011));
    chk("t2_warid_a", 160'(l_warid_o[9:0]), 160'({5'd2, 5'd1}));
    cycle();
    chk("t2_warid_b", 160'(l_warid_o[9:0]), 160'({5'd3, 5'd1}));

    // Exception in slot 2 (ROB index 10)
    push(1, 32'h301, 0, 0, 0, 0);
    push(2, 32'h302, 0, 0, 0, 0);
    push(3, 32'h303, 1, 0, 0, 0);
    push(4, 32'h304, 0, 0, 0, 0);
    cycle();
    chk("t3_ret_a", 160'(last_ret), 160'(4'b0011));
    cycle();
    chk("t3_ret_b", 160'(last_ret), 160'(4'b0001));
    cycle();
    chk("t3_excp", 160'({excp_valid_o, excp_rrid_o}), 160'({1'b1, 5'd10}));
    chk("t3_flush_on", 160'(l_flush_o), 160'(1));
    cycle();
    chk("t3_drain", 160'({l_retire_o, l_commit_o}), 160'({4'b0001, 4'b0000}));
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t3_flush_hold", 160'(l_flush_o), 160'(1));
    end
    ren_v = 1;
    cycle();
    ren_v = 0;
    chk("t3_flush_off", 160'(l_flush_o), 160'(0));

    // Uncached load at head (ROB index 12), LSU ready on 3rd request cycle
    push(5, 32'h1111, 0, 1, 0, 32'hDEADBEEF);
    push(6, 32'h66, 0, 0, 0, 0);
    cycle();
    chk("t4_ret", 160'(last_ret), 160'(4'b0001));
    wait_req();
    chk("t4_req", 160'({lsu_req_store_o, lsu_req_rrid_o}), 160'({1'b0, 5'd12}));
    cycle();
    chk("t4_req_hold1", 160'(lsu_req_valid_o), 160'(1));
    cycle();
    chk("t4_req_hold2", 160'(lsu_req_valid_o), 160'(1));
    lsu_rdy_v = 1; lsu_data_v = 32'hDEADBEEF;
    cycle();
    lsu_rdy_v = 0; lsu_data_v = '0;
    chk("t4_req_off", 160'(lsu_req_valid_o), 160'(0));
    chk("t4_commit", 160'(l_commit_o), 160'(4'b0001));
    chk("t4_data", 160'(l_data_o[31:0]), 160'(32'hDEADBEEF));
    chk("t4_flush", 160'(l_flush_o), 160'(1));
    cycle();
    cycle();
    ren_v = 1;
    cycle();
    ren_v = 0;
    chk("t4_flush_off", 160'(l_flush_o), 160'(0));

    // Uncached store (ROB index 14), ready in first request cycle
    push(0, 32'h5555, 0, 1, 1, 0);
    push(7, 32'h77, 0, 0, 0, 0);
    cycle();
    wait_req();
    chk("t5_req", 160'({lsu_req_store_o, lsu_req_rrid_o}), 160'({1'b1, 5'd14}));
    lsu_rdy_v = 1;
    cycle();
    lsu_rdy_v = 0;
    chk("t5_req_off", 160'(lsu_req_valid_o), 160'(0));
    chk("t5_commit", 160'(l_commit_o), 160'(4'b0001));
    chk("t5_noflush", 160'(l_flush_o), 160'(0));
    cycle();
    cycle();

    // Head wrap: fill 14 entries to reach index 30
    for (int i = 0; i < 14; i++) push(0, 32'h400 + i, 0, 0, 0, 0);
    for (int i = 0; i < 20 && rob_q.size() > 0; i++) cycle();
    chk("t6_head", 160'(rob_head_o), 160'(30));
    for (int k = 8; k < 12; k++) push(AW'(k), 32'h500 + k, 0, 0, 0, 0);
    cycle();
    chk("t6_ret", 160'(last_ret), 160'(4'b1111));
    cycle();
    chk("t6_wrrid", 160'(l_wrrid_o), 160'({5'd1, 5'd0, 5'd31, 5'd30}));
    cycle();
    cycle();
    chk("evq_empty", 160'(ev_q.size()), 160'(0));
    chk("excq_empty", 160'(exc_q.size()), 160'(0));
    chk("pre_rst_cnt", 160'(retired_cnt_o), 160'(cnt_m));

    // Reset while waiting on an uncached load
    push(9, 32'h99, 0, 1, 0, 32'hCAFE);
    cycle();
    wait_req();
    chk_en = 0;
    @(negedge clk);
    rst = 1'b1;
    rob_q.delete();
    drive();
    @(posedge clk);
    #1;
    chk("rst_req", 160'(lsu_req_valid_o), 160'(0));
    chk("rst_mid_outs", 160'({l_retire_o, l_commit_o, l_flush_o, excp_valid_o,
        rob_head_o, retire_o}), 160'(0));
    chk("rst_mid_cnt", 160'(retired_cnt_o), 160'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wired_commit_nw.md
# wired_commit_nw

Parametrised N-wide in-order commit stage for the Wired core. It reads up to COMMIT_W entries from the ROB head and picks a legal retire group. It registers the group into a handle stage, resolves exceptions and uncached memory operations through a small FSM, and drives registered ARF/rename update and flush outputs. It is the generalised successor of the fixed 2-wide commit: the width is parametrised, same-register conflicts are checked across all slots, and exception reporting and a retire counter are added.

## Interface
- COMMIT_W, 2, max instructions retired per cycle (1..4)
- ROB_LEN, 5, ROB index width; pointer wraps modulo 2^ROB_LEN
- ARF_W, 5, architectural register index width
- DATA_W, 32, data width
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- rob_valid_i  in  COMMIT_W  ROB entry head+k complete and ready to retire
- rob_wreg_i  in  COMMIT_W*ARF_W  destination arch reg per slot (0 = none)
- rob_wdata_i  in  COMMIT_W*DATA_W  result data per slot
- rob_excp_i / rob_single_i / rob_uncached_i / rob_store_i  in  COMMIT_W each  exception, must-retire-alone, uncached LSU op, store
- rob_head_o  out  ROB_LEN  ROB index of slot 0 (head)
- retire_o  out  COMMIT_W  pops ROB entries this cycle (thermometer: bit k implies bits <k)
- lsu_req_valid_o  out  1  uncached request; held until accepted
- lsu_req_store_o  out  1  1 = store, 0 = load
- lsu_req_rrid_o  out  ROB_LEN  ROB index of the request
- lsu_resp_ready_i  in  1  LSU completes request this cycle
- lsu_resp_data_i  in  DATA_W  uncached load data, valid with ready
- l_retire_o / l_commit_o  out  COMMIT_W each  rename retire / ARF write enable
- l_warid_o / l_wrrid_o / l_data_o  out  COMMIT_W*ARF_W / COMMIT_W*ROB_LEN / COMMIT_W*DATA_W  write target, ROB index, data
- l_flush_o  out  1  pipeline flush
- rename_empty_i  in  1  rename/ROB fully drained
- excp_valid_o  out  1  one-cycle exception report
- excp_rrid_o  out  ROB_LEN  ROB index of the excepting instruction
- retired_cnt_o  out  32  count of committed (ARF-written or architecturally retired) instructions, wraps

## Operation
- Selection (F, combinational), evaluated only when h_ready=1. Slot k is selected iff all of the following hold:
  - slot k-1 is selected (for k>0), and rob_valid_i[k].
  - For k>0: rob_single_i[k], rob_excp_i[k] and rob_uncached_i[k] are all 0.
  - For k>0: slot 0 has none of single/excp/uncached set.
  - rob_wreg_i[k] is 0, or it differs from rob_wreg_i[j] of every selected j<k.
- retire_o = selection mask. rob_head_o advances by popcount(retire_o) each cycle.
- H register: on h_ready it captures the group, the ROB indices head..head+COMMIT_W-1 (wrapping) and the valid mask. Its valid mask resets to 0.
- FSM states are NORMAL, WAIT_ULOAD, WAIT_USTORE and WAIT_FLUSH. Reset state is NORMAL.
  - NORMAL, slot 0 valid with excp: retire that slot with commit=0. Pulse excp_valid_o with its index. Go to WAIT_FLUSH.
  - NORMAL, slot 0 valid and uncached: h_ready=0, retire=0. Go to WAIT_ULOAD or WAIT_USTORE according to rob_store_i.
  - NORMAL, otherwise: retire = commit = valid mask; h_ready=1.
  - WAIT_ULOAD: lsu_req_valid_o=1, store=0, h_ready=0. When lsu_resp_ready_i=1: retire/commit slot 0 with data = lsu_resp_data_i, h_ready=1, go to WAIT_FLUSH.
  - WAIT_USTORE: same request with store=1. When ready: retire/commit slot 0, h_ready=1, go to NORMAL.
  - WAIT_FLUSH: l_flush=1, h_ready=1. Retire the H valid mask with commit=0, so younger entries are drained. Go to NORMAL when rename_empty_i=1.
- Commit rule: an instruction whose result is suppressed still asserts l_retire. Every ROB entry retires exactly once.
- retired_cnt_o increments by popcount(l_commit) plus exception retires, modulo 2^32.

## Timing
- ROB entry popped (retire_o) at cycle t. It is held in H during t+1. Its l_* outputs are registered and visible at t+2 in NORMAL.
- Uncached: lsu_req_valid_o is asserted from the cycle after entering WAIT_* until the cycle of lsu_resp_ready_i inclusive. Commit is visible the next cycle.
- lsu_resp_ready_i in the same cycle as the first request assertion completes in one cycle.
- l_flush_o is registered: high from the cycle after entering WAIT_FLUSH. It drops the cycle after rename_empty_i is sampled high.
- rst mid-operation: the next cycle returns the FSM to NORMAL, sets head to 0, clears H valid, and zeroes all outputs and the counter. Any pending LSU request is abandoned.
- Reset value of every output is 0.

## Test plan
- COMMIT_W=4, four valid entries with wregs 1,2,3,4 -> retire_o=4'b1111 at t; l_commit_o=4'b1111 at t+2; head +4; counter +4.
- Entries with wregs 1,2,1,3 -> retire_o=4'b0011, next cycle the remaining two retire; l_warid order preserved.
- Slot 2 has excp -> group 2'b11 retired; next cycle slot 0 = excp entry, excp_valid_o with its index; l_flush_o high until rename_empty_i; drained entries show commit=0.
- Uncached load at head, LSU ready after 3 cycles with data 0xDEADBEEF -> req held 3 cycles; l_data_o[0]=0xDEADBEEF, commit 1; then flush.
- Uncached store, ready in the first request cycle -> single-cycle request, commit slot 0, back to NORMAL with no flush.
- Head at 2^ROB_LEN-2 retiring 4 -> l_wrrid_o = 30,31,0,1 (ROB_LEN=5); rst asserted while in WAIT_ULOAD -> all outputs 0 next cycle.
